// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the packet-granular UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W      = 8;
  localparam int BURST_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_ACK,
    ST_DRAIN
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// N-way round-robin priority picker: the first set request strictly after
// 'last' (wrapping modulo N) wins. Purely combinational.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  int j;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 transmitter between N_REQ byte-stream requesters with
// round-robin arbitration at packet granularity and a per-grant burst cap.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 16,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*BYTE_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    grant_active,
  output logic [ID_W-1:0]         grant_id
);

  arb_state_e              state_q, state_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic                    grant_active_q, grant_active_d;
  logic [ID_W-1:0]         last_grant_q, last_grant_d;
  logic [BURST_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]       tx_data_q, tx_data_d;
  logic                    last_flag_q, last_flag_d;

  logic                    pick_any;
  logic [ID_W-1:0]         pick_idx;
  logic                    sel_valid;
  logic                    sel_last;
  logic [BYTE_W-1:0]       sel_data;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .last (last_grant_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign sel_valid = req_valid[grant_id_q];
  assign sel_last  = req_last[grant_id_q];
  assign sel_data  = req_data[int'(grant_id_q)*BYTE_W +: BYTE_W];

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    last_grant_d   = last_grant_q;
    byte_cnt_d     = byte_cnt_q;
    tx_data_d      = tx_data_q;
    last_flag_d    = last_flag_q;
    req_ready      = '0;
    tx_start       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_busy) begin
          grant_id_d     = pick_idx;
          grant_active_d = 1'b1;
          byte_cnt_d     = '0;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (sel_valid) begin
          req_ready[grant_id_q] = 1'b1;
          tx_data_d             = sel_data;
          last_flag_d           = sel_last;
          byte_cnt_d            = byte_cnt_q + BURST_CNT_W'(1);
          state_d               = ST_LAUNCH;
        end else begin
          // A gap inside a packet gives the link away rather than stalling it.
          last_grant_d   = grant_id_q;
          grant_active_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        tx_start = 1'b1;
        state_d  = ST_ACK;
      end
      ST_ACK: begin
        if (tx_busy) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (last_flag_q || (byte_cnt_q == BURST_CNT_W'(MAX_BURST))) begin
            last_grant_d   = grant_id_q;
            grant_active_d = 1'b0;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      last_grant_q   <= ID_W'(N_REQ - 1);
      byte_cnt_q     <= '0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      last_grant_q   <= last_grant_d;
      byte_cnt_q     <= byte_cnt_d;
      tx_data_q      <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    last_flag_q <= last_flag_d;
  end

  assign tx_data      = tx_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: lane queues feed requesters, a busy
// model stands in for the UART, and every tx_start is logged and compared.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        grant_active;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    int         cyc;
    logic [1:0] gid;
    logic [7:0] data;
  } ent_t;

  // One contention round: lanes in mask each offer a one-byte packet;
  // ord holds the expected service order as hex digits, first digit first.
  typedef struct packed {
    logic [3:0]  mask;
    logic [3:0]  n;
    logic [15:0] ord;
  } vec_t;

  beat_t lane_q [4][$];
  ent_t  log_q [$];
  vec_t  vecs [6];

  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         busy_cnt = 0;
  int         viol     = 0;
  logic       rst_next = 1'b1;
  logic [7:0] cur_byte = '0;
  bit         data_chk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] d, input logic l);
    beat_t b;
    b.last = l;
    b.data = d;
    lane_q[lane].push_back(b);
  endtask

  // One clock: drive at negedge, sample 1 unit later, DUT acts at next posedge.
  task automatic step();
    @(negedge clk);
    rst = rst_next;
    if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      tx_busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = lane_q[i][0].data;
        req_last[i]        = lane_q[i][0].last;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    #1;
    if (tx_start && tx_busy) viol++;
    if (data_chk && tx_busy && (tx_data !== cur_byte)) viol++;
    if (((req_ready & ~req_valid) != 4'b0) || !$onehot0(req_ready)) viol++;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) void'(lane_q[i].pop_front());
    end
    if (tx_start) begin
      ent_t e;
      e.cyc  = cyc;
      e.gid  = grant_id;
      e.data = tx_data;
      log_q.push_back(e);
      busy_cnt = 10;
      cur_byte = tx_data;
      data_chk = 1'b1;
    end
    cyc++;
  endtask

  function automatic bit all_done();
    bit empty;
    empty = 1'b1;
    for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) empty = 1'b0;
    return empty && !grant_active && (busy_cnt == 0) && !tx_busy;
  endfunction

  task automatic run_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_done() && n < budget);
    check({name, "_done"}, 32'(all_done()), 32'd1);
  endtask

  task automatic run_log(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (log_q.size() < cnt && n < budget) begin
      step();
      n++;
    end
    check({name, "_log"}, 32'(log_q.size() >= cnt), 32'd1);
  endtask

  task automatic check_seq(input string name, input logic [7:0] exp_d [], input logic [1:0] exp_g []);
    check({name, "_count"}, 32'(log_q.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), 32'(log_q[i].data), 32'(exp_d[i]));
      check($sformatf("%s_gid%0d", name, i), 32'(log_q[i].gid), 32'(exp_g[i]));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 32'h0);
    check({name, "_tx_start"}, 32'(tx_start), 32'h0);
    check({name, "_tx_data"}, 32'(tx_data), 32'h0);
    check({name, "_grant_active"}, 32'(grant_active), 32'h0);
    check({name, "_grant_id"}, 32'(grant_id), 32'h0);
  endtask

  initial begin
    int t0;
    logic [7:0] ed [];
    logic [1:0] eg [];

    // Reset
    rst_next = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst_held");
    rst_next = 1'b0;
    step();
    check_reset_outputs("rst_release");

    // Single packet from requester 0; last_grant becomes 0
    log_q.delete();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    t0 = cyc;
    run_done("single", 200);
    ed = '{8'h41, 8'h42};
    eg = '{2'd0, 2'd0};
    check_seq("single", ed, eg);
    if (log_q.size() >= 2) begin
      check("single_latency", 32'(log_q[0].cyc - t0), 32'd2);
      check("single_gap", 32'(log_q[1].cyc - log_q[0].cyc), 32'd13);
    end
    check("single_grant_active", 32'(grant_active), 32'd0);
    check("single_grant_id", 32'(grant_id), 32'd0);

    // Contention table, starting with last_grant=0
    vecs[0] = {4'b1010, 4'd2, 16'h0013};
    vecs[1] = {4'b1111, 4'd4, 16'h0123};
    vecs[2] = {4'b0101, 4'd2, 16'h0002};
    vecs[3] = {4'b0110, 4'd2, 16'h0012};
    vecs[4] = {4'b1011, 4'd3, 16'h0301};
    vecs[5] = {4'b1001, 4'd2, 16'h0030};
    for (int k = 0; k < 6; k++) begin
      log_q.delete();
      for (int i = 0; i < N; i++)
        if (vecs[k].mask[i]) push(i, {4'(i), 4'(k)}, 1'b1);
      run_done($sformatf("rr%0d", k), 400);
      check($sformatf("rr%0d_count", k), 32'(log_q.size()), 32'(vecs[k].n));
      for (int j = 0; j < int'(vecs[k].n) && j < log_q.size(); j++) begin
        logic [3:0] g;
        g = 4'(vecs[k].ord >> (4 * (int'(vecs[k].n) - 1 - j)));
        check($sformatf("rr%0d_gid%0d", k, j), 32'(log_q[j].gid), 32'(g));
        check($sformatf("rr%0d_data%0d", k, j), 32'(log_q[j].data), 32'({g, 4'(k)}));
      end
    end

    // req1 comes straight back with a second packet while req3 waits
    log_q.delete();
    push(1, 8'h11, 1'b1);
    push(1, 8'h12, 1'b1);
    push(3, 8'h33, 1'b1);
    run_done("rr_return", 400);
    ed = '{8'h11, 8'h33, 8'h12};
    eg = '{2'd1, 2'd3, 2'd1};
    check_seq("rr_return", ed, eg);

    // No interleave: req2 shows up in the middle of req0's packet
    log_q.delete();
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b1);
    run_log("nointl", 2, 100);
    push(2, 8'h2C, 1'b1);
    run_done("nointl", 300);
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'h2C};
    eg = '{2'd0, 2'd0, 2'd0, 2'd2};
    check_seq("nointl", ed, eg);

    // Burst cap of 4 with a competing single-byte packet
    log_q.delete();
    for (int i = 0; i < 10; i++) push(0, 8'hB0 + 8'(i), 1'b0);
    push(1, 8'h55, 1'b1);
    run_done("burst", 800);
    ed = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h55, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};
    eg = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    check_seq("burst", ed, eg);

    // Mid-packet drop on req2
    log_q.delete();
    push(2, 8'h20, 1'b0);
    run_done("drop", 100);
    repeat (30) step();
    ed = '{8'h20};
    eg = '{2'd2};
    check_seq("drop", ed, eg);
    check("drop_grant_active", 32'(grant_active), 32'd0);
    check("drop_grant_id", 32'(grant_id), 32'd2);

    // Reset while the transmitter is busy in DRAIN
    log_q.delete();
    push(0, 8'hC0, 1'b1);
    push(1, 8'hC1, 1'b1);
    run_log("rstdrain", 1, 50);
    repeat (3) step();
    data_chk = 1'b0;
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    step();
    check_reset_outputs("rstdrain");
    run_done("rstdrain", 200);
    ed = '{8'hC0, 8'hC1};
    eg = '{2'd0, 2'd1};
    check_seq("rstdrain", ed, eg);
    if (log_q.size() >= 2)
      check("rstdrain_gap", 32'(log_q[1].cyc - log_q[0].cyc), 32'd13);

    check("protocol_violations", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
